scan_decoder: RTL and testbench

Parametrised, registered one-hot decoder that generalises the fixed 2-to-4 and 3-to-8 decoders to SEL_W inputs and N_OUT outputs. It adds a self-timed scan mode that walks the active output through every position at a programmable dwell rate. It sits between the MIPS core's memory-mapped I/O registers and the FPGA board's multiplexed outputs (seven-segment anodes, LED banks), and is also usable as a plain registered select decoder.

---
 rtl/scan_decoder_pkg.sv | 18 +
 rtl/onehot_dec.sv | 34 +++
 rtl/scan_decoder.sv | 98 +++++++++
 tb/tb_scan_decoder.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/scan_decoder_pkg.sv
// rtl/scan_decoder_pkg.sv - shared mode constants and one-hot helper for scan_decoder
package scan_decoder_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Widest output vector the helper can describe; callers slice to their own width.
  localparam int MAX_OUT = 256;

  function automatic logic [MAX_OUT-1:0] onehot(input int unsigned sel, input int unsigned n_out);
    logic [MAX_OUT-1:0] v;
    v = '0;
    if (sel < n_out && sel < MAX_OUT)
      v = {{(MAX_OUT-1){1'b0}}, 1'b1} << sel;
    return v;
  endfunction

endpackage

// File: rtl/onehot_dec.sv
// rtl/onehot_dec.sv - combinational SEL_W-to-N_OUT one-hot decoder with enable, built as a binary tree
module onehot_dec #(
  parameter int SEL_W = 3,
  parameter int N_OUT = 8
) (
  input  logic             en,
  input  logic [SEL_W-1:0] sel,
  output logic [N_OUT-1:0] y
);

  localparam int LEAVES = 2**SEL_W;

  // Heap-ordered tree: node 0 is the enable, children of i are 2i+1 (bit=0) and 2i+2 (bit=1).
  logic [2*LEAVES-2:0] node;

  assign node[0] = en;

  for (genvar i = 0; i < LEAVES-1; i++) begin : g_node
    localparam int D = $clog2(i+2) - 1;
    assign node[2*i+1] = node[i] & ~sel[SEL_W-1-D];
    assign node[2*i+2] = node[i] &  sel[SEL_W-1-D];
  end

  assign y = node[LEAVES-1 +: N_OUT];

  if (N_OUT < LEAVES) begin : g_spare
    logic unused_leaves;
    assign unused_leaves = ^node[LEAVES-1+N_OUT +: (LEAVES-N_OUT)];
  end

  logic unused_inner;
  assign unused_inner = ^node[LEAVES-2:0];

endmodule

// File: rtl/scan_decoder.sv
// rtl/scan_decoder.sv - registered one-hot decoder with self-timed scan; optional blanking via SCAN_DECODER_BLANK_EN
module scan_decoder
  import scan_decoder_pkg::*;
#(
  parameter int SEL_W   = 3,
  parameter int N_OUT   = 8,
  parameter int DWELL_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               mode,
  input  logic               load,
  input  logic [SEL_W-1:0]   sel_in,
  input  logic [DWELL_W-1:0] dwell,
  output logic [N_OUT-1:0]   y,
  output logic [SEL_W-1:0]   cur_sel,
  output logic               wrap
);

  localparam logic [SEL_W-1:0] LAST = SEL_W'(N_OUT-1);

  logic [DWELL_W-1:0] cnt;
  logic               load_ok;
  logic               advance;
  logic               dec_en;
  logic [SEL_W-1:0]   next_sel;
  logic [N_OUT-1:0]   dec_y;

`ifdef SCAN_DECODER_BLANK_EN
  // Set on the advance edge; the next edge reveals the new position without counting.
  logic blank;
`endif

  always_comb begin
    load_ok  = |onehot(32'(sel_in), N_OUT);
    advance  = 1'b0;
    next_sel = cur_sel;
    dec_en   = en;
    if (en) begin
      if (mode == MODE_SCAN) begin
`ifdef SCAN_DECODER_BLANK_EN
        advance = !blank && (cnt >= dwell);
        dec_en  = !advance;
`else
        advance = (cnt >= dwell);
`endif
        if (advance)
          next_sel = (cur_sel == LAST) ? '0 : cur_sel + 1'b1;
      end else if (load && load_ok) begin
        next_sel = sel_in;
      end
    end
  end

  onehot_dec #(.SEL_W(SEL_W), .N_OUT(N_OUT)) u_dec (
    .en  (dec_en),
    .sel (next_sel),
    .y   (dec_y)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      y       <= '0;
      cur_sel <= '0;
      wrap    <= 1'b0;
      cnt     <= '0;
`ifdef SCAN_DECODER_BLANK_EN
      blank   <= 1'b1;
`endif
    end else begin
      y <= dec_y;
      if (!en) begin
        wrap <= 1'b0;
      end else begin
        cur_sel <= next_sel;
        wrap    <= advance && (cur_sel == LAST);
        if (mode == MODE_DIRECT) begin
          cnt <= '0;
`ifdef SCAN_DECODER_BLANK_EN
          blank <= 1'b0;
        end else if (blank) begin
          blank <= 1'b0;
        end else if (advance) begin
          cnt   <= '0;
          blank <= 1'b1;
`else
        end else if (advance) begin
          cnt <= '0;
`endif
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_scan_decoder.sv
// tb/tb_scan_decoder.sv - scoreboard bench for scan_decoder against a cycle-level reference model
module tb_scan_decoder;

  localparam int SEL_W   = 3;
  localparam int N_OUT   = 6;
  localparam int DWELL_W = 8;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               en = 1'b0;
  logic               mode = 1'b0;
  logic               load = 1'b0;
  logic [SEL_W-1:0]   sel_in = '0;
  logic [DWELL_W-1:0] dwell = '0;
  logic [N_OUT-1:0]   y;
  logic [SEL_W-1:0]   cur_sel;
  logic               wrap;

  scan_decoder #(.SEL_W(SEL_W), .N_OUT(N_OUT), .DWELL_W(DWELL_W)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load),
    .sel_in(sel_in), .dwell(dwell), .y(y), .cur_sel(cur_sel), .wrap(wrap)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned y;
    int unsigned sel;
    bit          wrap;
    string       tag;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;
  bit   stim_done = 0;

  // Reference state: position, dwell count, pending-reveal flag.
  int unsigned m_sel = 0, m_cnt = 0, m_y = 0;
  bit          m_wrap = 0, m_blank = 1;

  task automatic step(input bit r, input bit e, input bit m, input bit l,
                      input int unsigned s, input int unsigned d, input string tag);
    exp_t x;
    @(negedge clk);
    rst = r; en = e; mode = m; load = l;
    sel_in = SEL_W'(s); dwell = DWELL_W'(d);
    if (r) begin
      m_sel = 0; m_cnt = 0; m_y = 0; m_wrap = 0; m_blank = 1;
    end else if (!e) begin
      m_y = 0; m_wrap = 0;
    end else if (!m) begin
      if (l && s < N_OUT) m_sel = s;
      m_y = 1 << m_sel; m_cnt = 0; m_wrap = 0; m_blank = 0;
    end else begin
      m_wrap = 0;
`ifdef SCAN_DECODER_BLANK_EN
      if (m_blank) begin
        m_blank = 0;
        m_y = 1 << m_sel;
      end else if (m_cnt >= d) begin
        m_cnt = 0;
        m_wrap = (m_sel == N_OUT-1);
        m_sel = (m_sel + 1) % N_OUT;
        m_y = 0;
        m_blank = 1;
      end else begin
        m_cnt++;
        m_y = 1 << m_sel;
      end
`else
      if (m_cnt >= d) begin
        m_cnt = 0;
        m_wrap = (m_sel == N_OUT-1);
        m_sel = (m_sel + 1) % N_OUT;
      end else begin
        m_cnt++;
      end
      m_y = 1 << m_sel;
`endif
    end
    x.y = m_y; x.sel = m_sel; x.wrap = m_wrap; x.tag = tag;
    q.push_back(x);
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        vectors++;
        if (int'(y) != int'(x.y) || int'(cur_sel) != int'(x.sel) || wrap != x.wrap) begin
          miscompares++;
          $display("FAIL %s @%0t: got y=%h cur_sel=%0d wrap=%0b, expected y=%h cur_sel=%0d wrap=%0b",
                   x.tag, $time, y, cur_sel, wrap, x.y[N_OUT-1:0], x.sel, x.wrap);
        end
      end
    end
  end

  initial begin : stimulus
    int unsigned d;
    bit          m, e, r;
    // Reset
    step(1, 0, 0, 0, 0, 0, "reset");
    step(1, 0, 0, 0, 0, 0, "reset");
    // Direct decode, out-of-range loads ignored
    step(0, 1, 0, 1, 5, 0, "direct_load5");
    step(0, 1, 0, 0, 0, 0, "direct_hold");
    step(0, 1, 0, 1, 7, 0, "direct_load7");
    step(0, 1, 0, 1, 6, 0, "direct_load6");
    step(0, 0, 0, 1, 2, 0, "direct_en_low");
    step(0, 1, 0, 0, 2, 0, "direct_en_back");
    step(0, 1, 0, 1, 0, 0, "direct_load0");
    // Scan sweep dwell=2 with load asserted (scan wins)
    for (int i = 0; i < 2*N_OUT*3 + 2; i++) step(0, 1, 1, 1, 3, 2, "scan_sweep");
    // Enable drop mid-dwell
    step(0, 1, 1, 0, 0, 4, "pre_drop");
    step(0, 1, 1, 0, 0, 4, "pre_drop");
    for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 0, 4, "en_drop");
    for (int i = 0; i < 2*N_OUT*5; i++) step(0, 1, 1, 0, 0, 4, "after_drop");
    // Dwell shortened below the running count
    for (int i = 0; i < 11; i++) step(0, 1, 1, 0, 0, 20, "dwell_long");
    for (int i = 0; i < N_OUT*5 + 3; i++) step(0, 1, 1, 0, 0, 4, "dwell_short");
    // Reset mid-scan for two cycles, then resume
    step(1, 1, 1, 0, 0, 1, "reset_midscan");
    step(1, 1, 1, 0, 0, 1, "reset_midscan");
    for (int i = 0; i < 3*N_OUT; i++) step(0, 1, 1, 0, 0, 0, "dwell0");
    // Randomised traffic
    d = 2; m = 1;
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 199) == 0);
      e = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 39) == 0) m = ~m;
      if ($urandom_range(0, 29) == 0)
        d = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 20) : $urandom_range(0, 5);
      step(r, e, m, $urandom_range(0, 1), $urandom_range(0, 7), d, "random");
    end
    @(negedge clk);
    stim_done = 1;
  end

  initial begin : finisher
    int budget;
    wait (stim_done);
    budget = 0;
    while (q.size() > 0 && budget < 20) begin
      @(posedge clk);
      budget++;
    end
    #2;
    if (q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected vectors left, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    miscompares++;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
